rr_arbiter4_v: RTL and testbench

RR_ARBITER4_V -- requirements
Module: rr_arbiter4_v

---
 rtl/rr_arbiter4_v.sv | 108 ++++++++++
 tb/tb_rr_arbiter4_v.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/rr_arbiter4_v.sv
// Four-way round-robin arbiter with registered one-hot grant and a hold
// limit that forces release after MAX_HOLD cycles of ownership.
module rr_arbiter4_v #(
    parameter int unsigned MAX_HOLD = 15
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [3:0] i_req,
    input  logic       i_done,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_busy,
    output logic       o_any_req
);

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t     state, state_nxt;
    logic [1:0] ptr, ptr_nxt;
    logic [7:0] hold_cnt, hold_nxt;
    logic [3:0] gnt_nxt;
    logic [1:0] gnt_id_nxt;
    logic       busy_nxt;

    logic [1:0] win;
    logic       found;
    logic [1:0] cand;
    logic       release_now;

    assign o_any_req = |i_req;

    // Search starts one past the last winner, so the previous owner ends up lowest priority.
    always_comb begin
        win   = '0;
        found = 1'b0;
        cand  = '0;
        for (int unsigned k = 1; k <= 4; k++) begin
            cand = ptr + 2'(k);
            if (!found && i_req[cand]) begin
                win   = cand;
                found = 1'b1;
            end
        end
    end

    assign release_now = i_done || !i_req[o_gnt_id] || (hold_cnt == 8'(MAX_HOLD));

    always_comb begin
        state_nxt  = state;
        ptr_nxt    = ptr;
        hold_nxt   = hold_cnt;
        gnt_nxt    = o_gnt;
        gnt_id_nxt = o_gnt_id;
        busy_nxt   = o_busy;
        unique case (state)
            IDLE: begin
                gnt_nxt  = '0;
                busy_nxt = 1'b0;
                if (found) begin
                    state_nxt  = GRANT;
                    gnt_nxt    = 4'b0001 << win;
                    gnt_id_nxt = win;
                    busy_nxt   = 1'b1;
                    hold_nxt   = 8'd1;
                end
            end
            GRANT: begin
                if (release_now) begin
                    state_nxt = IDLE;
                    gnt_nxt   = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = o_gnt_id;
                    hold_nxt  = '0;
                end else begin
                    hold_nxt = hold_cnt + 8'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
                hold_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= IDLE;
            ptr      <= 2'd3;
            hold_cnt <= '0;
            o_gnt    <= '0;
            o_gnt_id <= '0;
            o_busy   <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            hold_cnt <= hold_nxt;
            o_gnt    <= gnt_nxt;
            o_gnt_id <= gnt_id_nxt;
            o_busy   <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_rr_arbiter4_v.sv
// Scoreboard bench for rr_arbiter4_v: a behavioural model queues the expected
// registered outputs per cycle; they are popped and compared after each edge.
module tb_rr_arbiter4_v;

    localparam int unsigned MAX_HOLD = 15;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [3:0] i_req = '0;
    logic       i_done = 1'b0;
    logic [3:0] o_gnt;
    logic [1:0] o_gnt_id;
    logic       o_busy;
    logic       o_any_req;

    rr_arbiter4_v #(.MAX_HOLD(MAX_HOLD)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_req     (i_req),
        .i_done    (i_done),
        .o_gnt     (o_gnt),
        .o_gnt_id  (o_gnt_id),
        .o_busy    (o_busy),
        .o_any_req (o_any_req)
    );

    always #5 i_clk = ~i_clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Expected {gnt, gnt_id, busy} per cycle.
    logic [6:0] exp_q[$];

    // Reference model state
    logic       m_busy = 1'b0;
    logic [1:0] m_ptr  = 2'd3;
    int         m_hold = 0;
    logic [3:0] m_gnt  = '0;
    logic [1:0] m_id   = '0;

    int grant_log[$];

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        n_checks++;
        if (obs === expv) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, expv, $time);
    endtask

    task automatic model_step(input logic [3:0] req, input logic done, input logic rst);
        logic [7:0] dbl;
        logic [3:0] rot;
        int         pick;
        if (rst) begin
            m_busy = 1'b0; m_ptr = 2'd3; m_hold = 0; m_gnt = '0; m_id = '0;
        end else if (!m_busy) begin
            m_gnt = '0;
            if (req != 4'b0) begin
                // Rotate so that bit 0 of rot is requester ptr+1.
                dbl  = {req, req};
                rot  = 4'(dbl >> (int'(m_ptr) + 1));
                pick = 0;
                while (!rot[pick]) pick++;
                m_id   = 2'((int'(m_ptr) + 1 + pick) % 4);
                m_gnt  = 4'(1 << m_id);
                m_busy = 1'b1;
                m_hold = 1;
            end
        end else begin
            if (done || !req[m_id] || m_hold == int'(MAX_HOLD)) begin
                m_ptr  = m_id;
                m_busy = 1'b0;
                m_gnt  = '0;
                m_hold = 0;
            end else begin
                m_hold++;
            end
        end
        exp_q.push_back({m_gnt, m_id, m_busy});
    endtask

    task automatic cycle(input logic [3:0] req, input logic done, input logic rst);
        logic [6:0] e;
        i_req  = req;
        i_done = done;
        i_rst  = rst;
        #1;
        check("any_req", 8'(o_any_req), 8'(|req));
        model_step(req, done, rst);
        @(posedge i_clk);
        #1;
        if (exp_q.size() == 0) begin
            check("queue_empty", 8'd1, 8'd0);
        end else begin
            e = exp_q.pop_front();
            check("gnt", 8'(o_gnt), 8'(e[6:3]));
            check("busy", 8'(o_busy), 8'(e[0]));
            check("gnt_id", 8'(o_gnt_id), 8'(e[2:1]));
            if (o_busy) check("onehot", 8'($countones(o_gnt)), 8'd1);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt_hold;
        logic prev_busy;
        @(posedge i_clk); #1;

        // Reset state
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0000, 1'b0, 1'b1);
        check("rst_gnt", 8'(o_gnt), 8'd0);
        check("rst_id", 8'(o_gnt_id), 8'd0);

        // Full request, done one cycle after each grant: 0,1,2,3,0
        prev_busy = 1'b0;
        for (int i = 0; i < 10; i++) begin
            cycle(4'b1111, 1'(i % 2), 1'b0);
            if (o_busy && !prev_busy) grant_log.push_back(int'(o_gnt_id));
            prev_busy = o_busy;
        end
        check("order_len", 8'(grant_log.size()), 8'd5);
        if (grant_log.size() == 5) begin
            check("order0", 8'(grant_log[0]), 8'd0);
            check("order1", 8'(grant_log[1]), 8'd1);
            check("order2", 8'(grant_log[2]), 8'd2);
            check("order3", 8'(grant_log[3]), 8'd3);
            check("order4", 8'(grant_log[4]), 8'd0);
        end

        // Single requester held: 15 grant cycles, 1 idle, re-grant
        cycle(4'b0000, 1'b0, 1'b1);
        cnt_hold = 0;
        cycle(4'b0100, 1'b0, 1'b0);
        while (o_gnt == 4'b0100 && cnt_hold < 40) begin
            cnt_hold++;
            cycle(4'b0100, 1'b0, 1'b0);
        end
        check("hold_len", 8'(cnt_hold), 8'(MAX_HOLD));
        check("hold_gap", 8'(o_gnt), 8'd0);
        cycle(4'b0100, 1'b0, 1'b0);
        check("hold_regrant", 8'(o_gnt), 8'b0100);
        for (int i = 0; i < 20; i++) cycle(4'b0100, 1'b0, 1'b0);

        // Owner 1 drops request while 3 waits
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        check("own1", 8'(o_gnt), 8'b0010);
        cycle(4'b1000, 1'b0, 1'b0);
        check("drop_clear", 8'(o_gnt), 8'd0);
        cycle(4'b1000, 1'b0, 1'b0);
        check("drop_next", 8'(o_gnt), 8'b1000);

        // Reset during grant, then requester 0 wins
        cycle(4'b0000, 1'b0, 1'b1);
        cycle(4'b0010, 1'b0, 1'b0);
        cycle(4'b0011, 1'b0, 1'b1);
        check("rst_drop", 8'(o_gnt), 8'd0);
        cycle(4'b0011, 1'b0, 1'b0);
        check("rst_regrant", 8'(o_gnt), 8'b0001);

        // No requests, done toggling: stays idle
        cycle(4'b0000, 1'b0, 1'b1);
        for (int i = 0; i < 6; i++) cycle(4'b0000, 1'(i % 2), 1'b0);
        check("idle_busy", 8'(o_busy), 8'd0);
        cycle(4'b0001, 1'b1, 1'b0);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            cycle(4'($urandom_range(0, 15)), ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 40) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
